// File: rtl/ram_bridge_posted.sv
// CPU-bus to SDRAM-controller bridge with EMS page windows and a posted-write FIFO.
// Optional read forwarding from pending FIFO entries: define RAM_READ_FORWARD_EN.
module ram_bridge_posted #(
  parameter int ADDR_WIDTH     = 20,
  parameter int CTL_ADDR_WIDTH = 25,
  parameter int EMS_PAGES      = 4,
  parameter int EMS_MAP_WIDTH  = 7,
  parameter int EMS_PAGE_BITS  = 14,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [ADDR_WIDTH-1:0]              address,
  input  logic [7:0]                         data_in,
  output logic [7:0]                         data_out,
  input  logic                               memory_read_n,
  input  logic                               memory_write_n,
  input  logic                               ram_address_select_n,
  input  logic                               no_command_state,
  input  logic [EMS_PAGES*EMS_MAP_WIDTH-1:0] ems_map,
  input  logic [EMS_PAGES-1:0]               ems_hit,
  output logic                               memory_access_ready,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic [CTL_ADDR_WIDTH-1:0]          ctl_address,
  output logic [15:0]                        ctl_data_in,
  input  logic [15:0]                        ctl_data_out,
  output logic                               ctl_write_request,
  output logic                               ctl_read_request,
  input  logic                               ctl_write_flag,
  input  logic                               ctl_read_flag,
  input  logic                               ctl_idle,
  output logic                               ctl_enable_refresh,
  output logic [1:0]                         ctl_byte_mask
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RD_DONE = 3'd5;
  localparam logic [2:0] S_ABORT   = 3'd6;

  logic                      w_wr_cmd, w_rd_cmd, w_wr_edge, w_rd_edge;
  logic                      r_wr_cmd_d, r_rd_cmd_d, r_ncs_d;
  logic [2:0]                r_state, w_state_nx;
  logic [CTL_ADDR_WIDTH-1:0] w_xlat_addr;
  logic [CTL_ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [7:0]                r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wptr, r_rptr;
  logic [LVL_W-1:0]          r_count;
  logic                      w_full, w_empty, w_pop, w_push, w_push_new, w_push_pend;
  logic [CTL_ADDR_WIDTH-1:0] w_push_addr;
  logic [7:0]                w_push_data;
  logic                      r_wr_pend;
  logic [CTL_ADDR_WIDTH-1:0] r_pend_addr;
  logic [7:0]                r_pend_data;
  logic                      r_rd_pending, r_ready;
  logic [CTL_ADDR_WIDTH-1:0] r_rd_addr;
  logic [7:0]                r_data_out;
  logic                      w_fwd_hit;
  logic [7:0]                w_fwd_data;
  logic                      w_unused;

  assign w_unused  = ^ctl_data_out[15:8];
  assign w_wr_cmd  = ~ram_address_select_n & ~memory_write_n;
  assign w_rd_cmd  = ~ram_address_select_n & ~memory_read_n;
  assign w_wr_edge = w_wr_cmd & ~r_wr_cmd_d;
  assign w_rd_edge = w_rd_cmd & ~r_rd_cmd_d;

  // Scan high-to-low so the lowest hitting window is the last (winning) assignment.
  always_comb begin
    w_xlat_addr = CTL_ADDR_WIDTH'(address);
    for (int i = EMS_PAGES-1; i >= 0; i--)
      if (ems_hit[i])
        w_xlat_addr = CTL_ADDR_WIDTH'({1'b1, ems_map[i*EMS_MAP_WIDTH +: EMS_MAP_WIDTH],
                                       address[EMS_PAGE_BITS-1:0]});
  end

  assign w_full      = (r_count == LVL_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = (r_state == S_WR_WAIT) & ~ctl_write_flag;
  assign w_push_new  = w_wr_edge & (~w_full | w_pop);
  assign w_push_pend = r_wr_pend & w_pop;
  assign w_push      = w_push_new | w_push_pend;
  assign w_push_addr = r_wr_pend ? r_pend_addr : w_xlat_addr;
  assign w_push_data = r_wr_pend ? r_pend_data : data_in;
  assign fifo_level  = r_count;

`ifdef RAM_READ_FORWARD_EN
  // Oldest-to-youngest scan: the youngest matching entry wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = 8'h00;
    for (int k = 0; k < FIFO_DEPTH; k++)
      if ((LVL_W'(k) < r_count) && (r_fifo_addr[r_rptr + PTR_W'(k)] == w_xlat_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_fifo_data[r_rptr + PTR_W'(k)];
      end
  end
`else
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = 8'h00;
`endif

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= w_push_addr;
      r_fifo_data[r_wptr] <= w_push_data;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (!w_empty) w_state_nx = S_WR_REQ;
                 else if (r_rd_pending) w_state_nx = S_RD_REQ;
      S_WR_REQ:  if (ctl_write_flag) w_state_nx = S_WR_WAIT;
      S_WR_WAIT: if (!ctl_write_flag) w_state_nx = S_IDLE;
      S_RD_REQ:  if (!w_rd_cmd) w_state_nx = S_ABORT;
                 else if (ctl_read_flag) w_state_nx = S_RD_WAIT;
      S_RD_WAIT: if (!w_rd_cmd) w_state_nx = S_ABORT;
                 else if (!ctl_read_flag) w_state_nx = S_RD_DONE;
      S_RD_DONE: if (!w_rd_cmd) w_state_nx = S_IDLE;
      S_ABORT:   if (ctl_idle) w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_wr_cmd_d   <= 1'b0;
      r_rd_cmd_d   <= 1'b0;
      r_ncs_d      <= 1'b1;  // no refresh pulse straight out of reset
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_wr_pend    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= 8'h00;
      r_rd_pending <= 1'b0;
      r_ready      <= 1'b1;
      r_rd_addr    <= '0;
      r_data_out   <= 8'h00;
    end else begin
      r_state    <= w_state_nx;
      r_wr_cmd_d <= w_wr_cmd;
      r_rd_cmd_d <= w_rd_cmd;
      r_ncs_d    <= no_command_state;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      if (w_wr_edge && w_full && !w_pop) begin
        r_wr_pend   <= 1'b1;
        r_pend_addr <= w_xlat_addr;
        r_pend_data <= data_in;
        r_ready     <= 1'b0;
      end else if (w_push_pend) begin
        r_wr_pend <= 1'b0;
        r_ready   <= 1'b1;
      end

      if (w_rd_edge) begin
        r_rd_addr <= w_xlat_addr;
        if (w_fwd_hit) r_data_out <= w_fwd_data;
        else begin
          r_rd_pending <= 1'b1;
          r_ready      <= 1'b0;
        end
      end

      case (r_state)
        S_RD_REQ, S_RD_WAIT: begin
          if (!w_rd_cmd) begin
            r_rd_pending <= 1'b0;
            r_ready      <= 1'b1;
          end else begin
            if (ctl_read_flag) r_data_out <= ctl_data_out[7:0];
            if (r_state == S_RD_WAIT && !ctl_read_flag) begin
              r_rd_pending <= 1'b0;
              r_ready      <= 1'b1;
            end
          end
        end
        S_ABORT: r_rd_pending <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    ctl_write_request = (r_state == S_WR_REQ);
    ctl_read_request  = (r_state == S_RD_REQ);
    ctl_byte_mask     = 2'b00;
    ctl_address       = '0;
    ctl_data_in       = 16'h0000;
    case (r_state)
      S_WR_REQ, S_WR_WAIT: begin
        ctl_byte_mask = 2'b10;
        ctl_address   = r_fifo_addr[r_rptr];
        ctl_data_in   = {8'h00, r_fifo_data[r_rptr]};
      end
      S_RD_REQ, S_RD_WAIT, S_RD_DONE: ctl_address = r_rd_addr;
      S_ABORT:  ctl_byte_mask = 2'b11;
      default: ;
    endcase
  end

  assign memory_access_ready = (w_rd_cmd | w_wr_cmd) ? r_ready : 1'b1;
  assign data_out            = (w_rd_cmd || r_state == S_RD_WAIT) ? r_data_out : 8'h00;
  assign ctl_enable_refresh  = no_command_state & ~r_ncs_d;

endmodule

// File: tb/tb_ram_bridge_posted.sv
// Directed bench for ram_bridge_posted: table-driven write/translation vectors
// plus hand-written sequences for FIFO-full, read ordering, abort, reset and refresh.
module tb_ram_bridge_posted;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] address = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        memory_read_n = 1'b1, memory_write_n = 1'b1, ram_address_select_n = 1'b1;
  logic        no_command_state = 1'b1;
  logic [27:0] ems_map = {7'h7F, 7'h55, 7'h2C, 7'h01};
  logic [3:0]  ems_hit = '0;
  logic        memory_access_ready;
  logic [2:0]  fifo_level;
  logic [24:0] ctl_address;
  logic [15:0] ctl_data_in;
  logic [15:0] ctl_data_out = '0;
  logic        ctl_write_request, ctl_read_request;
  logic        ctl_write_flag = 1'b0, ctl_read_flag = 1'b0, ctl_idle = 1'b1;
  logic        ctl_enable_refresh;
  logic [1:0]  ctl_byte_mask;

  ram_bridge_posted dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data_in(data_in),
    .data_out(data_out), .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .ram_address_select_n(ram_address_select_n), .no_command_state(no_command_state),
    .ems_map(ems_map), .ems_hit(ems_hit), .memory_access_ready(memory_access_ready),
    .fifo_level(fifo_level), .ctl_address(ctl_address), .ctl_data_in(ctl_data_in),
    .ctl_data_out(ctl_data_out), .ctl_write_request(ctl_write_request),
    .ctl_read_request(ctl_read_request), .ctl_write_flag(ctl_write_flag),
    .ctl_read_flag(ctl_read_flag), .ctl_idle(ctl_idle),
    .ctl_enable_refresh(ctl_enable_refresh), .ctl_byte_mask(ctl_byte_mask)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
    logic [3:0]  hit;
    logic [24:0] exp_addr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [19:0] a, input logic [7:0] d, input logic [3:0] h);
    address = a; data_in = d; ems_hit = h;
    ram_address_select_n = 1'b0; memory_write_n = 1'b0;
    #1 chk("wr_ready", {31'b0, memory_access_ready}, 32'd1);
    tick();
    memory_write_n = 1'b1; ram_address_select_n = 1'b1; ems_hit = '0;
  endtask

  task automatic wait_req(input bit rd);
    int n = 0;
    while ((rd ? ctl_read_request : ctl_write_request) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(rd ? "rd_req_seen" : "wr_req_seen", {31'b0, rd ? ctl_read_request : ctl_write_request}, 32'd1);
  endtask

  task automatic ack_write(input logic [24:0] ea, input logic [7:0] ed);
    chk("wr_addr", {7'b0, ctl_address}, {7'b0, ea});
    chk("wr_data", {16'b0, ctl_data_in}, {24'b0, ed});
    chk("wr_mask", {30'b0, ctl_byte_mask}, 32'd2);
    ctl_write_flag = 1'b1;
    tick();
    chk("wr_wait_req", {31'b0, ctl_write_request}, 32'd0);
    chk("wr_wait_mask", {30'b0, ctl_byte_mask}, 32'd2);
    ctl_write_flag = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Window map: 0->7'h01, 1->7'h2C, 2->7'h55, 3->7'h7F. EMS address = {1, page, addr[13:0]}.
    vecs[0] = '{20'h12345, 8'h5A, 4'b0000, 25'h0012345};
    vecs[1] = '{20'hD4567, 8'h3C, 4'b0110, 25'h02B0567};
    vecs[2] = '{20'hFFFFF, 8'hFF, 4'b1000, 25'h03FFFFF};
    vecs[3] = '{20'h00000, 8'h00, 4'b0001, 25'h0204000};
    vecs[4] = '{20'hABCDE, 8'h81, 4'b1100, 25'h0357CDE};
    vecs[5] = '{20'h00100, 8'hA5, 4'b0000, 25'h0000100};

    // Reset state, with the refresh input high to confirm no pulse.
    repeat (2) tick();
    chk("rst_ready", {31'b0, memory_access_ready}, 32'd1);
    chk("rst_level", {29'b0, fifo_level}, 32'd0);
    chk("rst_wreq", {31'b0, ctl_write_request}, 32'd0);
    chk("rst_rreq", {31'b0, ctl_read_request}, 32'd0);
    chk("rst_mask", {30'b0, ctl_byte_mask}, 32'd0);
    chk("rst_addr", {7'b0, ctl_address}, 32'd0);
    chk("rst_dout", {24'b0, data_out}, 32'd0);
    chk("rst_refresh", {31'b0, ctl_enable_refresh}, 32'd0);
    reset_n = 1'b1;
    no_command_state = 1'b0;
    tick();

    // Translation + posted write vectors, controller flags two cycles after the request.
    for (int i = 0; i < 6; i++) begin
      cpu_write(vecs[i].addr, vecs[i].data, vecs[i].hit);
      chk("vec_level1", {29'b0, fifo_level}, 32'd1);
      wait_req(1'b0);
      tick(); tick();
      chk("vec_req_held", {31'b0, ctl_write_request}, 32'd1);
      ack_write(vecs[i].exp_addr, vecs[i].data);
      chk("vec_level0", {29'b0, fifo_level}, 32'd0);
      chk("vec_idle_addr", {7'b0, ctl_address}, 32'd0);
    end

    // Five back-to-back writes with the controller stalled.
    for (int i = 0; i < 4; i++) begin
      cpu_write(20'h00010 + 20'(i), 8'h10 + 8'(i), 4'h0);
      tick();
    end
    chk("full_level", {29'b0, fifo_level}, 32'd4);
    address = 20'h00014; data_in = 8'h14;
    ram_address_select_n = 1'b0; memory_write_n = 1'b0;
    tick();
    chk("full_ready0a", {31'b0, memory_access_ready}, 32'd0);
    tick();
    chk("full_ready0b", {31'b0, memory_access_ready}, 32'd0);
    chk("full_level_hold", {29'b0, fifo_level}, 32'd4);
    chk("full_head", {7'b0, ctl_address}, 32'h10);
    ctl_write_flag = 1'b1;
    tick();
    chk("full_ready0c", {31'b0, memory_access_ready}, 32'd0);
    ctl_write_flag = 1'b0;
    tick();
    chk("full_ready1", {31'b0, memory_access_ready}, 32'd1);
    chk("full_level_swap", {29'b0, fifo_level}, 32'd4);
    memory_write_n = 1'b1; ram_address_select_n = 1'b1;
    for (int i = 1; i < 5; i++) begin
      wait_req(1'b0);
      ack_write(25'h10 + 25'(i), 8'h10 + 8'(i));
    end
    chk("drain_level", {29'b0, fifo_level}, 32'd0);

    // Write then read the same address: read waits for the write to pop.
    cpu_write(20'h00100, 8'hA5, 4'h0);
    address = 20'h00100; ram_address_select_n = 1'b0; memory_read_n = 1'b0;
    tick();
    chk("wr_rd_ready0", {31'b0, memory_access_ready}, 32'd0);
    chk("wr_rd_wreq", {31'b0, ctl_write_request}, 32'd1);
    chk("wr_rd_no_rreq", {31'b0, ctl_read_request}, 32'd0);
    ack_write(25'h100, 8'hA5);
    chk("wr_rd_level0", {29'b0, fifo_level}, 32'd0);
    chk("wr_rd_no_rreq2", {31'b0, ctl_read_request}, 32'd0);
    tick();
    chk("rd_req", {31'b0, ctl_read_request}, 32'd1);
    chk("rd_mask", {30'b0, ctl_byte_mask}, 32'd0);
    chk("rd_addr", {7'b0, ctl_address}, 32'h100);
    ctl_read_flag = 1'b1; ctl_data_out = 16'hFFA5;
    tick();
    chk("rd_wait_req", {31'b0, ctl_read_request}, 32'd0);
    chk("rd_wait_dout", {24'b0, data_out}, 32'hA5);
    tick();
    ctl_read_flag = 1'b0; ctl_data_out = 16'h0000;
    tick();
    chk("rd_done_ready", {31'b0, memory_access_ready}, 32'd1);
    chk("rd_done_dout", {24'b0, data_out}, 32'hA5);
    memory_read_n = 1'b1; ram_address_select_n = 1'b1;
    #1 chk("rd_release_dout", {24'b0, data_out}, 32'd0);
    tick();

    // Read dropped by the CPU before the controller answers.
    ctl_idle = 1'b0;
    address = 20'h00300; ram_address_select_n = 1'b0; memory_read_n = 1'b0;
    tick(); tick();
    chk("abort_rreq", {31'b0, ctl_read_request}, 32'd1);
    memory_read_n = 1'b1; ram_address_select_n = 1'b1;
    tick();
    chk("abort_mask", {30'b0, ctl_byte_mask}, 32'd3);
    chk("abort_no_req", {31'b0, ctl_read_request}, 32'd0);
    tick();
    chk("abort_mask_hold", {30'b0, ctl_byte_mask}, 32'd3);
    ctl_idle = 1'b1;
    tick();
    chk("abort_exit_mask", {30'b0, ctl_byte_mask}, 32'd0);

    // Reset asserted while in RD_REQ.
    address = 20'h00400; ram_address_select_n = 1'b0; memory_read_n = 1'b0;
    tick(); tick();
    chk("midrst_rreq", {31'b0, ctl_read_request}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, memory_access_ready}, 32'd1);
    chk("midrst_level", {29'b0, fifo_level}, 32'd0);
    chk("midrst_rreq0", {31'b0, ctl_read_request}, 32'd0);
    chk("midrst_wreq0", {31'b0, ctl_write_request}, 32'd0);
    memory_read_n = 1'b1; ram_address_select_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("postrst_rreq", {31'b0, ctl_read_request}, 32'd0);
    chk("postrst_mask", {30'b0, ctl_byte_mask}, 32'd0);

    // Refresh pulse on the rising edge of no_command_state.
    no_command_state = 1'b1;
    #1 chk("refresh_pulse", {31'b0, ctl_enable_refresh}, 32'd1);
    tick();
    chk("refresh_single", {31'b0, ctl_enable_refresh}, 32'd0);
    no_command_state = 1'b0;
    tick();

`ifdef RAM_READ_FORWARD_EN
    // Two stalled writes to one address, then a read of it: youngest data forwarded.
    cpu_write(20'h00200, 8'h11, 4'h0);
    tick();
    cpu_write(20'h00200, 8'h22, 4'h0);
    tick();
    chk("fwd_level", {29'b0, fifo_level}, 32'd2);
    address = 20'h00200; ram_address_select_n = 1'b0; memory_read_n = 1'b0;
    tick();
    chk("fwd_dout", {24'b0, data_out}, 32'h22);
    chk("fwd_ready", {31'b0, memory_access_ready}, 32'd1);
    chk("fwd_no_rreq", {31'b0, ctl_read_request}, 32'd0);
    memory_read_n = 1'b1; ram_address_select_n = 1'b1;
    wait_req(1'b0);
    ack_write(25'h200, 8'h11);
    wait_req(1'b0);
    ack_write(25'h200, 8'h22);
    tick();
    chk("fwd_no_rreq2", {31'b0, ctl_read_request}, 32'd0);
    chk("fwd_level0", {29'b0, fifo_level}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
